edge_detector: RTL and testbench

- Per-bit rising, falling and any-edge detector on a WIDTH-bit input sampled by one clock.
- Holds a one-cycle delayed copy of the input (q) and compares it with the current input.
- Keeps saturating rise/fall event counters for status and debug.
- Sits after slow control or status inputs and turns level changes into single-cycle pulses for downstream FSMs.

---
 rtl/edge_detector.sv | 75 +++++++
 tb/tb_edge_detector.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/edge_detector.sv
// Per-bit rising/falling/any-edge detector with saturating bit-0 event counters.
// Optional EDGE_SYNC_EN adds a 2-flop input synchronizer ahead of detection.
module edge_detector #(
   parameter int unsigned      WIDTH = 1,
   parameter int unsigned      CNT_W = 8,
   parameter logic [WIDTH-1:0] RST_Q = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] outp,
   output logic [WIDTH-1:0] outn,
   output logic [WIDTH-1:0] outb,
   output logic [WIDTH-1:0] q,
   output logic [CNT_W-1:0] rise_cnt,
   output logic [CNT_W-1:0] fall_cnt,
   input  logic             cnt_clr
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [WIDTH-1:0] d;

`ifdef EDGE_SYNC_EN
   logic [WIDTH-1:0] sync_ff1;
   logic [WIDTH-1:0] sync_ff2;

   // Synchronizer resets to RST_Q so no spurious edge appears after reset release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_ff1 <= RST_Q;
         sync_ff2 <= RST_Q;
      end else begin
         sync_ff1 <= din;
         sync_ff2 <= sync_ff1;
      end
   end

   assign d = sync_ff2;
`else
   assign d = din;
`endif

   // NOTE: non-blocking assignments in clocked blocks so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= RST_Q;
      end else begin
         q <= d;
      end
   end

   assign outp = d & ~q;
   assign outn = ~d & q;
   assign outb = d ^ q;

   // Clear wins over increment; each counter sticks at all-ones instead of wrapping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rise_cnt <= '0;
         fall_cnt <= '0;
      end else if (cnt_clr) begin
         rise_cnt <= '0;
         fall_cnt <= '0;
      end else begin
         if (outp[0] && (rise_cnt != CNT_MAX)) begin
            rise_cnt <= rise_cnt + 1'b1;
         end
         if (outn[0] && (fall_cnt != CNT_MAX)) begin
            fall_cnt <= fall_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_edge_detector.sv
// Directed self-checking bench for edge_detector (default build, no synchronizer).
// Main instance is 4 bits wide; a second 1-bit, CNT_W=2 instance covers saturation.
module tb_edge_detector;

   logic       clk;
   logic       rst_n;
   logic [3:0] din;
   logic       cnt_clr;
   logic [3:0] outp, outn, outb, q;
   logic [7:0] rise_cnt, fall_cnt;

   logic       din_s;
   logic       cnt_clr_s;
   logic [0:0] outp_s, outn_s, outb_s, q_s;
   logic [1:0] rise_cnt_s, fall_cnt_s;

   int n_checks;
   int n_fail;
   int exp_rise;
   int exp_fall;

   edge_detector #(.WIDTH(4), .CNT_W(8), .RST_Q(4'b0000)) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .din      (din),
      .outp     (outp),
      .outn     (outn),
      .outb     (outb),
      .q        (q),
      .rise_cnt (rise_cnt),
      .fall_cnt (fall_cnt),
      .cnt_clr  (cnt_clr)
   );

   edge_detector #(.WIDTH(1), .CNT_W(2), .RST_Q(1'b0)) u_sat (
      .clk      (clk),
      .rst_n    (rst_n),
      .din      (din_s),
      .outp     (outp_s),
      .outn     (outn_s),
      .outb     (outb_s),
      .q        (q_s),
      .rise_cnt (rise_cnt_s),
      .fall_cnt (fall_cnt_s),
      .cnt_clr  (cnt_clr_s)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_edges(input string tag, input logic [3:0] ep, input logic [3:0] en,
                              input logic [3:0] eq);
      check({tag, ".outp"}, 32'(outp), 32'(ep));
      check({tag, ".outn"}, 32'(outn), 32'(en));
      check({tag, ".outb"}, 32'(outb), 32'(ep | en));
      check({tag, ".q"},    32'(q),    32'(eq));
   endtask

   task automatic check_cnts(input string tag, input int er, input int ef);
      check({tag, ".rise_cnt"}, 32'(rise_cnt), 32'(er));
      check({tag, ".fall_cnt"}, 32'(fall_cnt), 32'(ef));
   endtask

   initial begin
      n_checks  = 0;
      n_fail    = 0;
      rst_n     = 1'b0;
      din       = 4'b0000;
      cnt_clr   = 1'b0;
      din_s     = 1'b0;
      cnt_clr_s = 1'b0;

      // Reset state
      #12;
      check_edges("reset", 4'b0000, 4'b0000, 4'b0000);
      check_cnts("reset", 0, 0);
      @(negedge clk) rst_n = 1'b1;

      // Idle low for 3 cycles
      repeat (3) @(posedge clk);
      #1;
      check_edges("idle", 4'b0000, 4'b0000, 4'b0000);
      check_cnts("idle", 0, 0);

      // Rising edge on bit 0, held for 3 posedges
      @(negedge clk) din = 4'b0001;
      #1;
      check_edges("rise_comb", 4'b0001, 4'b0000, 4'b0000);
      @(posedge clk); #1;
      check_edges("rise_after", 4'b0000, 4'b0000, 4'b0001);
      check_cnts("rise_after", 1, 0);
      repeat (2) @(posedge clk);
      #1;
      check_edges("rise_hold", 4'b0000, 4'b0000, 4'b0001);
      check_cnts("rise_hold", 1, 0);

      // Falling edge on bit 0
      @(negedge clk) din = 4'b0000;
      #1;
      check_edges("fall_comb", 4'b0000, 4'b0001, 4'b0001);
      @(posedge clk); #1;
      check_edges("fall_after", 4'b0000, 4'b0000, 4'b0000);
      check_cnts("fall_after", 1, 1);

      // Independent per-bit edges; bit 0 stays low so counters do not move
      @(negedge clk) din = 4'b1010;
      #1;
      check_edges("multi1", 4'b1010, 4'b0000, 4'b0000);
      @(negedge clk) din = 4'b0110;
      #1;
      check_edges("multi2", 4'b0100, 4'b1000, 4'b1010);
      @(negedge clk) din = 4'b0000;
      #1;
      check_edges("multi3", 4'b0000, 4'b0110, 4'b0110);
      @(posedge clk); #1;
      check_cnts("multi", 1, 1);

      // Clear has priority over a simultaneous rise, then over a fall
      @(negedge clk) begin din = 4'b0001; cnt_clr = 1'b1; end
      @(posedge clk); #1;
      check_cnts("clr_vs_rise", 0, 0);
      @(negedge clk) din = 4'b0000;
      @(posedge clk); #1;
      check_cnts("clr_vs_fall", 0, 0);
      @(negedge clk) cnt_clr = 1'b0;

      // Four toggles at negedge: alternating single-cycle pulses
      exp_rise = 0;
      exp_fall = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk) din[0] = ~din[0];
         #1;
         if (din[0]) begin
            check_edges($sformatf("tog%0d", i), 4'b0001, 4'b0000, 4'b0000);
            exp_rise++;
         end else begin
            check_edges($sformatf("tog%0d", i), 4'b0000, 4'b0001, 4'b0001);
            exp_fall++;
         end
      end
      @(posedge clk); #1;
      check_cnts("toggle", exp_rise, exp_fall);
      check("toggle.rise_is_2", 32'(rise_cnt), 32'd2);

      // Reset mid-operation with q=1 and din=1
      @(negedge clk) din = 4'b0001;
      @(posedge clk); #1;
      check_edges("pre_rst", 4'b0000, 4'b0000, 4'b0001);
      check_cnts("pre_rst", 3, 2);
      @(negedge clk) rst_n = 1'b0;
      #1;
      check_edges("in_rst", 4'b0001, 4'b0000, 4'b0000);
      check_cnts("in_rst", 0, 0);
      @(posedge clk); #1;
      check_cnts("in_rst_edge", 0, 0);
      check("in_rst_edge.q", 32'(q), 32'd0);
      @(negedge clk) rst_n = 1'b1;
      #1;
      check("post_rst.outp", 32'(outp), 32'b0001);
      @(posedge clk); #1;
      check_edges("post_rst", 4'b0000, 4'b0000, 4'b0001);
      check_cnts("post_rst", 1, 0);

      // Saturation on the CNT_W=2 instance
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk) din_s = 1'b1;
         @(negedge clk) din_s = 1'b0;
         #1;
         check($sformatf("sat_rise%0d", k), 32'(rise_cnt_s), (k > 3) ? 32'd3 : 32'(k));
      end
      @(posedge clk); #1;
      check("sat.fall_cnt", 32'(fall_cnt_s), 32'd3);
      @(negedge clk) cnt_clr_s = 1'b1;
      @(posedge clk); #1;
      check("sat_clr.rise_cnt", 32'(rise_cnt_s), 32'd0);
      check("sat_clr.fall_cnt", 32'(fall_cnt_s), 32'd0);
      @(negedge clk) cnt_clr_s = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
